ucie_ctl_sb_rx_decoder: RTL
===========================

# ucie_ctl_sb_rx_decoder

Parametrised sideband receive decoder for the UCIe controller RDI side. It accepts sideband packets as a stream of 32-bit phases, supports back-to-back packets with no idle gap, and decodes 2-phase (no-data) and 4-phase (64-bit data) messages. Decoded messages, with per-message error flags, go into a P_DEPTH-entry buffer drained by a valid/ready handshake. Each drained entry returns one credit to the remote transmitter.

## Interface
- P_DEPTH, 4, message buffer entries; power of two, ≥2; equals the transmitter's initial credit count
- P_SRC_ID, 3'b001, expected phase0[31:29]
- P_DST_ID, 3'b101, expected phase1[26:24]
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-low
- i_rx_vld  in  1  one phase beat is present on i_rx_data this cycle
- i_rx_data  in  32  phase data
- i_rx_abort  in  1  discard the partial packet and return to PH0
- o_msg_vld  out  1  buffer head valid
- i_msg_rdy  in  1  consumer accepts the head
- o_msg_decode  out  5  decode code of the head entry
- o_msg_data  out  64  {phase3, phase2}; zero for no-data messages
- o_msg_err  out  5  head entry flags: [0] src, [1] dst, [2] opcode, [3] unsupported, [4] parity
- o_crd_ret  out  1  one-cycle pulse per pop
- o_err_sticky  out  6  OR of pushed o_msg_err bits; [5] overflow
- i_err_clr  in  1  clears o_err_sticky

## Operation
- States: PH0, PH1, PH2, PH3. PH0 is also the wait state. The state advances only on beats where i_rx_vld=1.
- PH0 beat: capture the header. opcode=[4:0], msgcode=[21:14], src check against [31:29], partial parity ^data. Go to PH1.
- PH1 beat:
  - Checks: subcode=[7:0]; msginfo=[23:8] must be 0 (else unsupported); dst check against [26:24].
  - cp error if [30] != ^{[29:0], phase0}. Latch dp=[31].
  - If opcode=5'b11011, go to PH2. Otherwise push and go to PH0.
- PH2 beat: data low. Go to PH3.
- PH3 beat: data high. dp error if dp != ^{ph2, ph3}. Push, then go to PH0.
- Decode:
  - Opcode 5'b10010 (no data): decode[4]=1.
    - msgcode 0x03 → [3:2]=01; 0x04 → 10; 0x09 → 11. Any other msgcode → 00 with unsupported.
    - For 01/10, subcode 0x01 → [1:0]=01 and 0x09 → 11.
    - For 11, subcode 0x00/0x01/0x02 → 00/01/10.
    - Any other subcode → 00 with unsupported.
  - Opcode 5'b11011 (data): decode[4:2]=000 requires msgcode 0x01 and subcode 0x00; otherwise unsupported.
  - Any other opcode: opcode error. The packet is treated as 2-phase, pushed with decode=0.
- Push: one entry holding {decode, data, err}. A push happens even if error bits are set.
- Overflow: a push while the buffer is full and no pop occurs in the same cycle.
  - The entry is dropped and o_err_sticky[5] is set.
  - Parsing continues normally.
- Pop when o_msg_vld & i_msg_rdy. The same cycle, o_crd_ret=1.
- i_rx_abort takes priority over i_rx_vld. Any state goes to PH0, no push occurs, and the partial header is discarded.
- o_err_sticky: bits set on push with corresponding o_msg_err; cleared when i_err_clr=1. If set and clear occur in the same cycle, set wins.

## Timing
- Reset values:
  - State PH0 and buffer empty.
  - o_msg_vld=0, o_msg_decode=0, o_msg_data=0, o_msg_err=0.
  - o_crd_ret=0, o_err_sticky=0.
  - No credit pulses are issued at reset.
- Latency: a push happens at the clock edge ending the last beat. o_msg_vld=1 in the next cycle.
- Throughput: one phase per cycle; back-to-back packets without gaps.
- Simultaneous push and pop when full: both happen, with no overflow.
- Simultaneous push and pop when empty: the pushed entry appears next cycle. It cannot be popped in the push cycle (no bypass).
- Outputs are stable while o_msg_vld=1 and i_msg_rdy=0.
- Pointer width is log2(P_DEPTH)+1, with a wrap bit for the full/empty distinction.
- Reset mid-packet or mid-drain: everything returns to reset values immediately.

## Structure
- Package ucie_ctl_sb_pkg holds:
  - opcode constants (MSG_NO_DATA=5'b10010, MSG_DATA=5'b11011)
  - msgcode and subcode constants
  - decode encodings
  - error bit indices
  - the entry width, 5+64+5
- Sub-module ucie_ctl_sb_rx_fifo: parametrised synchronous FIFO with P_DEPTH and width ports, and full/empty flags. The decoder FSM instantiates it.

## Test plan
- No-data message: PH0 opcode 10010, msgcode 0x04, src 001; PH1 subcode 0x09, dst 101, correct cp → decode=5'b11011, err=0, vld the cycle after PH1. Pop with rdy=1 → one crd_ret pulse.
- Data message: opcode 11011, msgcode 0x01, subcode 0x00; ph2=0xDEADBEEF, ph3=0x12345678; dp correct → data=0x12345678DEADBEEF, decode=0.
- Errors: the same no-data packet with src=010, dst=100, flipped cp → err=5'b10011, and o_err_sticky matches. i_err_clr=1 → sticky returns to 0.
- Overflow: P_DEPTH+1 back-to-back no-data packets with rdy=0 → first P_DEPTH entries stored in order, last dropped, sticky[5]=1. Repeat with a pop on the last push cycle → no overflow.
- Abort: raise i_rx_abort after PH2 of a data packet, then send a valid no-data packet → exactly one entry, the no-data one.
- Unsupported/opcode: msgcode 0x07 with no-data opcode → unsupported flag set and decode[3:2]=00. Opcode 5'b00001 → opcode flag set, 2-phase length, next packet decoded correctly.

Source files
------------

// File: rtl/ucie_ctl_sb_pkg.sv
// Shared constants, types and the message decode table for the UCIe sideband receive path.
package ucie_ctl_sb_pkg;

    localparam logic [4:0] MSG_NO_DATA = 5'b10010;
    localparam logic [4:0] MSG_DATA    = 5'b11011;

    localparam logic [7:0] MC_DATA     = 8'h01;
    localparam logic [7:0] MC_ND_GRP1  = 8'h03;
    localparam logic [7:0] MC_ND_GRP2  = 8'h04;
    localparam logic [7:0] MC_ND_GRP3  = 8'h09;

    localparam logic [7:0] SC_00 = 8'h00;
    localparam logic [7:0] SC_01 = 8'h01;
    localparam logic [7:0] SC_02 = 8'h02;
    localparam logic [7:0] SC_09 = 8'h09;

    localparam logic [1:0] DEC_GRP_NONE = 2'b00;
    localparam logic [1:0] DEC_GRP1     = 2'b01;
    localparam logic [1:0] DEC_GRP2     = 2'b10;
    localparam logic [1:0] DEC_GRP3     = 2'b11;

    localparam int unsigned ERR_SRC   = 0;
    localparam int unsigned ERR_DST   = 1;
    localparam int unsigned ERR_OPC   = 2;
    localparam int unsigned ERR_UNSUP = 3;
    localparam int unsigned ERR_PAR   = 4;
    localparam int unsigned ERR_OVF   = 5;

    localparam int unsigned DEC_W   = 5;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned ERR_W   = 5;
    localparam int unsigned ENTRY_W = DEC_W + DATA_W + ERR_W;

    typedef enum logic [1:0] {
        StPh0,
        StPh1,
        StPh2,
        StPh3
    } rx_state_e;

    typedef struct packed {
        logic [DEC_W-1:0]  decode;
        logic [DATA_W-1:0] data;
        logic [ERR_W-1:0]  err;
    } sb_msg_t;

    typedef struct packed {
        logic [DEC_W-1:0] decode;
        logic             unsup;
        logic             opc_err;
    } sb_dec_t;

    function automatic sb_dec_t decode_msg(input logic [4:0] opcode,
                                           input logic [7:0] msgcode,
                                           input logic [7:0] subcode);
        sb_dec_t r;
        r = '0;
        if (opcode == MSG_NO_DATA) begin
            r.decode[4] = 1'b1;
            case (msgcode)
                MC_ND_GRP1: r.decode[3:2] = DEC_GRP1;
                MC_ND_GRP2: r.decode[3:2] = DEC_GRP2;
                MC_ND_GRP3: r.decode[3:2] = DEC_GRP3;
                default:    r.unsup = 1'b1;
            endcase
            if (r.decode[3:2] == DEC_GRP1 || r.decode[3:2] == DEC_GRP2) begin
                case (subcode)
                    SC_01:   r.decode[1:0] = 2'b01;
                    SC_09:   r.decode[1:0] = 2'b11;
                    default: r.unsup = 1'b1;
                endcase
            end else if (r.decode[3:2] == DEC_GRP3) begin
                case (subcode)
                    SC_00:   r.decode[1:0] = 2'b00;
                    SC_01:   r.decode[1:0] = 2'b01;
                    SC_02:   r.decode[1:0] = 2'b10;
                    default: r.unsup = 1'b1;
                endcase
            end
        end else if (opcode == MSG_DATA) begin
            r.unsup = (msgcode != MC_DATA) || (subcode != SC_00);
        end else begin
            r.opc_err = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ucie_ctl_sb_rx_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push while full is accepted only alongside a pop.
module ucie_ctl_sb_rx_fifo #(
    parameter int unsigned P_DEPTH = 4,
    parameter int unsigned P_WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_push,
    input  logic [P_WIDTH-1:0] i_wdata,
    input  logic               i_pop,
    output logic [P_WIDTH-1:0] o_rdata,
    output logic               o_full,
    output logic               o_empty
);

    localparam int unsigned AW = $clog2(P_DEPTH);

    logic [AW:0]        wr_ptr_q, rd_ptr_q;
    logic [P_WIDTH-1:0] mem_q [P_DEPTH];
    logic               do_push, do_pop;

    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = i_pop & ~o_empty;
    assign do_push = i_push & (~o_full | do_pop);
    assign o_rdata = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/ucie_ctl_sb_rx_decoder.sv
// Sideband receive decoder: parses 2/4-phase packets, checks header fields and parity,
// buffers decoded messages and returns one credit per consumed entry.
module ucie_ctl_sb_rx_decoder
    import ucie_ctl_sb_pkg::*;
#(
    parameter int unsigned P_DEPTH  = 4,
    parameter logic [2:0]  P_SRC_ID = 3'b001,
    parameter logic [2:0]  P_DST_ID = 3'b101
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rx_vld,
    input  logic [31:0] i_rx_data,
    input  logic        i_rx_abort,
    output logic        o_msg_vld,
    input  logic        i_msg_rdy,
    output logic [4:0]  o_msg_decode,
    output logic [63:0] o_msg_data,
    output logic [4:0]  o_msg_err,
    output logic        o_crd_ret,
    output logic [5:0]  o_err_sticky,
    input  logic        i_err_clr
);

    rx_state_e state_q, state_d;

    logic [4:0]  opcode_q;
    logic [7:0]  msgcode_q;
    logic        src_err_q;
    logic        par0_q;
    logic [4:0]  err_q;
    logic        dp_q;
    logic [31:0] data_lo_q;
    logic [5:0]  sticky_q, sticky_d;

    sb_dec_t      ph1_dec;
    logic [4:0]   ph1_err;
    logic         beat;
    logic         push, pop, overflow;
    sb_msg_t      push_msg, head;
    logic [ENTRY_W-1:0] head_raw;
    logic         fifo_full, fifo_empty;

    assign beat = i_rx_vld & ~i_rx_abort;

    // Header checks evaluated on the PH1 beat, against the header captured at PH0.
    always_comb begin
        ph1_dec            = decode_msg(opcode_q, msgcode_q, i_rx_data[7:0]);
        ph1_err            = '0;
        ph1_err[ERR_SRC]   = src_err_q;
        ph1_err[ERR_DST]   = (i_rx_data[26:24] != P_DST_ID);
        ph1_err[ERR_OPC]   = ph1_dec.opc_err;
        ph1_err[ERR_UNSUP] = ph1_dec.unsup | (|i_rx_data[23:8]);
        ph1_err[ERR_PAR]   = i_rx_data[30] ^ (^i_rx_data[29:0]) ^ par0_q;
    end

    always_comb begin
        state_d  = state_q;
        push     = 1'b0;
        push_msg = '0;
        if (i_rx_abort) begin
            state_d = StPh0;
        end else if (i_rx_vld) begin
            case (state_q)
                StPh0: state_d = StPh1;
                StPh1: begin
                    if (opcode_q == MSG_DATA) begin
                        state_d = StPh2;
                    end else begin
                        push            = 1'b1;
                        push_msg.decode = ph1_dec.decode;
                        push_msg.err    = ph1_err;
                        state_d         = StPh0;
                    end
                end
                StPh2: state_d = StPh3;
                StPh3: begin
                    push                  = 1'b1;
                    push_msg.decode       = '0;
                    push_msg.data         = {i_rx_data, data_lo_q};
                    push_msg.err          = err_q;
                    push_msg.err[ERR_PAR] = err_q[ERR_PAR] | (dp_q ^ (^{data_lo_q, i_rx_data}));
                    state_d               = StPh0;
                end
                default: state_d = StPh0;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= StPh0;
            opcode_q  <= '0;
            msgcode_q <= '0;
            src_err_q <= 1'b0;
            par0_q    <= 1'b0;
            err_q     <= '0;
            dp_q      <= 1'b0;
            data_lo_q <= '0;
        end else begin
            state_q <= state_d;
            if (beat) begin
                case (state_q)
                    StPh0: begin
                        opcode_q  <= i_rx_data[4:0];
                        msgcode_q <= i_rx_data[21:14];
                        src_err_q <= (i_rx_data[31:29] != P_SRC_ID);
                        par0_q    <= ^i_rx_data;
                    end
                    StPh1: begin
                        err_q <= ph1_err;
                        dp_q  <= i_rx_data[31];
                    end
                    StPh2: data_lo_q <= i_rx_data;
                    default: ;
                endcase
            end
        end
    end

    ucie_ctl_sb_rx_fifo #(
        .P_DEPTH (P_DEPTH),
        .P_WIDTH (ENTRY_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_wdata (push_msg),
        .i_pop   (pop),
        .o_rdata (head_raw),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign head      = sb_msg_t'(head_raw);
    assign o_msg_vld = ~fifo_empty;
    assign pop       = o_msg_vld & i_msg_rdy;
    assign o_crd_ret = pop;
    assign overflow  = push & fifo_full & ~pop;

    // Storage is not reset, so fields are forced to zero whenever the head is invalid.
    always_comb begin
        o_msg_decode = '0;
        o_msg_data   = '0;
        o_msg_err    = '0;
        if (o_msg_vld) begin
            o_msg_decode = head.decode;
            o_msg_data   = head.data;
            o_msg_err    = head.err;
        end
    end

    // Set wins over clear in the same cycle.
    always_comb begin
        sticky_d = i_err_clr ? 6'b0 : sticky_q;
        if (push) sticky_d[4:0] = sticky_d[4:0] | push_msg.err;
        if (overflow) sticky_d[ERR_OVF] = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) sticky_q <= '0;
        else        sticky_q <= sticky_d;
    end

    assign o_err_sticky = sticky_q;

endmodule
